// File: rtl/chase_pair_array.sv
// chase_pair_array: N independent leader/follower counter pairs.
// In every channel the follower may close in on its leader but never pass
// it, and the leader never wraps away from a follower that is still behind.
// Exports the counters, per-pair gap and catch status, a global invariant
// (prop) and a sticky violation flag (viol).
// Optional feature: define CHASE_ASSERT_EN to compile in concurrent
// assertions on the invariant and on leader progress.
module chase_pair_array #(
  parameter int W   = 4,
  parameter int N   = 2,
  parameter int SAT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             clr,
  input  logic [N-1:0]             lead_step,
  input  logic [N-1:0]             follow_step,
  output logic [N*W-1:0]           lead,
  output logic [N*W-1:0]           follow,
  output logic [N*W-1:0]           gap,
  output logic [N-1:0]             caught,
  output logic [$clog2(N+1)-1:0]   n_caught,
  output logic                     prop,
  output logic                     viol
);

  localparam int CW = $clog2(N+1);
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] lead_q   [N];
  logic [W-1:0] lead_d   [N];
  logic [W-1:0] follow_q [N];
  logic [W-1:0] follow_d [N];
  logic         viol_q;
  logic         viol_d;

  // Per-channel next-state: clear first, then the joint advance/wrap cases,
  // then the independent leader and follower rules.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      lead_d[i]   = lead_q[i];
      follow_d[i] = follow_q[i];
      if (clr[i]) begin
        lead_d[i]   = '0;
        follow_d[i] = '0;
      end else if (lead_step[i] && follow_step[i] && (follow_q[i] == lead_q[i])) begin
        if (lead_q[i] != MAX) begin
          lead_d[i]   = lead_q[i] + ONE;
          follow_d[i] = follow_q[i] + ONE;
        end else if (SAT == 0) begin
          lead_d[i]   = '0;
          follow_d[i] = '0;
        end
      end else begin
        if (lead_step[i] && (lead_q[i] != MAX)) begin
          lead_d[i] = lead_q[i] + ONE;
        end
        if (follow_step[i] && (follow_q[i] < lead_q[i])) begin
          follow_d[i] = follow_q[i] + ONE;
        end
      end
    end
  end

  // The violation flag latches any cycle in which the invariant is low.
  always_comb begin
    viol_d = viol_q | ~prop;
  end

  // Counter and sticky-flag registers; reset zeroes everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        lead_q[i]   <= '0;
        follow_q[i] <= '0;
      end
      viol_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        lead_q[i]   <= lead_d[i];
        follow_q[i] <= follow_d[i];
      end
      viol_q <= viol_d;
    end
  end

  // Pack counters onto the flat buses and derive gap, catch status and prop.
  always_comb begin
    lead     = '0;
    follow   = '0;
    gap      = '0;
    caught   = '0;
    n_caught = '0;
    prop     = 1'b1;
    for (int i = 0; i < N; i++) begin
      lead[i*W +: W]   = lead_q[i];
      follow[i*W +: W] = follow_q[i];
      gap[i*W +: W]    = lead_q[i] - follow_q[i];
      caught[i]        = (follow_q[i] == lead_q[i]);
      n_caught         = n_caught + CW'(caught[i]);
      if (follow_q[i] > lead_q[i]) begin
        prop = 1'b0;
      end
    end
  end

  assign viol = viol_q;

`ifdef CHASE_ASSERT_EN
  // The follower never overtakes its leader on any channel.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (prop);
    end
  end

  a_prop: assert property (@(posedge clk) disable iff (!rst_n) prop);

  for (genvar g = 0; g < N; g++) begin : g_lead_progress
    // A leader step below MAX (and not cleared) must advance the leader.
    a_no_stall: assert property (@(posedge clk) disable iff (!rst_n)
      (lead_step[g] && !clr[g] && (lead_q[g] != MAX))
        |=> (lead_q[g] == $past(lead_q[g]) + ONE));
  end
`else
  // Without the macro no assertions are emitted; prop and viol remain
  // available for external checkers.
`endif

endmodule

// File: tb/tb_chase_pair_array.sv
// Self-checking bench for chase_pair_array (W=4, N=2, SAT=0).
// Directed scenarios followed by randomized traffic, all compared against
// an integer reference model of the chase rules.
module tb_chase_pair_array;

  localparam int W   = 4;
  localparam int N   = 2;
  localparam int SAT = 0;
  localparam int MAXV = (1 << W) - 1;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   clr;
  logic [N-1:0]   leadStep;
  logic [N-1:0]   followStep;
  logic [N*W-1:0] lead;
  logic [N*W-1:0] follow;
  logic [N*W-1:0] gap;
  logic [N-1:0]   caught;
  logic [1:0]     nCaught;
  logic           prop;
  logic           viol;

  int checkCount = 0;
  int passCount  = 0;

  int mLead   [N];
  int mFollow [N];
  bit mViol;

  chase_pair_array #(.W(W), .N(N), .SAT(SAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .lead_step  (leadStep),
    .follow_step(followStep),
    .lead       (lead),
    .follow     (follow),
    .gap        (gap),
    .caught     (caught),
    .n_caught   (nCaught),
    .prop       (prop),
    .viol       (viol)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model reset: every pair back to 0/0 and the flag cleared.
  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mLead[i]   = 0;
      mFollow[i] = 0;
    end
    mViol = 1'b0;
  endtask

  // Reference model for one rising edge, using the inputs currently driven.
  task automatic modelEdge();
    bit propNow;
    int l;
    int f;
    propNow = 1'b1;
    for (int i = 0; i < N; i++) if (mFollow[i] > mLead[i]) propNow = 1'b0;
    if (!rst_n) begin
      modelReset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      l = mLead[i];
      f = mFollow[i];
      if (clr[i]) begin
        l = 0;
        f = 0;
      end else if (leadStep[i] && followStep[i] && f == l) begin
        if (l < MAXV) begin
          l++;
          f++;
        end else if (SAT == 0) begin
          l = 0;
          f = 0;
        end
      end else begin
        if (leadStep[i] && mLead[i] < MAXV) l = mLead[i] + 1;
        if (followStep[i] && mFollow[i] < mLead[i]) f = mFollow[i] + 1;
      end
      mLead[i]   = l;
      mFollow[i] = f;
    end
    mViol = mViol | !propNow;
  endtask

  // Compare every output against the model state.
  task automatic compareAll();
    int cnt;
    bit p;
    cnt = 0;
    p = 1'b1;
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("lead%0d", i), 32'(lead[i*W +: W]), 32'(mLead[i]));
      checkOutput($sformatf("follow%0d", i), 32'(follow[i*W +: W]), 32'(mFollow[i]));
      checkOutput($sformatf("gap%0d", i), 32'(gap[i*W +: W]), 32'((mLead[i] - mFollow[i]) & MAXV));
      checkOutput($sformatf("caught%0d", i), 32'(caught[i]), 32'(mLead[i] == mFollow[i]));
      if (mLead[i] == mFollow[i]) cnt++;
      if (mFollow[i] > mLead[i]) p = 1'b0;
    end
    checkOutput("n_caught", 32'(nCaught), 32'(cnt));
    checkOutput("prop", 32'(prop), 32'(p));
    checkOutput("viol", 32'(viol), 32'(mViol));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // sample outputs 1 ns after the edge.
  task automatic applyStimulus(input logic [N-1:0] c, input logic [N-1:0] ls, input logic [N-1:0] fs);
    clr        = c;
    leadStep   = ls;
    followStep = fs;
    modelEdge();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  initial begin
    rst_n      = 1'b0;
    clr        = '0;
    leadStep   = '0;
    followStep = '0;
    modelReset();

    // Reset held with random steps: everything stays at zero.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(N'($urandom), N'($urandom), N'($urandom));
    end
    checkOutput("rst_caught", 32'(caught), 32'(2'b11));
    checkOutput("rst_n_caught", 32'(nCaught), 32'd2);
    checkOutput("rst_viol", 32'(viol), 32'd0);
    rst_n = 1'b1;

    // Leader alone on ch0 for five cycles.
    for (int k = 0; k < 5; k++) applyStimulus(2'b00, 2'b01, 2'b00);
    checkOutput("lo_lead0", 32'(lead[3:0]), 32'd5);
    checkOutput("lo_gap0", 32'(gap[3:0]), 32'd5);
    checkOutput("lo_caught", 32'(caught), 32'(2'b10));
    checkOutput("lo_n_caught", 32'(nCaught), 32'd1);

    // Follower catches up and clamps at the leader.
    for (int k = 0; k < 8; k++) applyStimulus(2'b00, 2'b00, 2'b01);
    checkOutput("clamp_follow0", 32'(follow[3:0]), 32'd5);
    checkOutput("clamp_gap0", 32'(gap[3:0]), 32'd0);

    // Joint run from 0 to MAX, then joint wrap.
    applyStimulus(2'b01, 2'b00, 2'b00);
    for (int k = 0; k < 15; k++) applyStimulus(2'b00, 2'b01, 2'b01);
    checkOutput("joint_lead0", 32'(lead[3:0]), 32'd15);
    checkOutput("joint_follow0", 32'(follow[3:0]), 32'd15);
    applyStimulus(2'b00, 2'b01, 2'b01);
    checkOutput("wrap_lead0", 32'(lead[3:0]), 32'd0);
    checkOutput("wrap_follow0", 32'(follow[3:0]), 32'd0);

    // Build 15/10 on ch0, stall the leader at MAX, then catch up and wrap.
    for (int k = 0; k < 15; k++) applyStimulus(2'b00, 2'b01, 2'b00);
    for (int k = 0; k < 10; k++) applyStimulus(2'b00, 2'b00, 2'b01);
    for (int k = 0; k < 3; k++) applyStimulus(2'b00, 2'b01, 2'b00);
    checkOutput("stall_lead0", 32'(lead[3:0]), 32'd15);
    checkOutput("stall_follow0", 32'(follow[3:0]), 32'd10);
    for (int k = 0; k < 5; k++) applyStimulus(2'b00, 2'b00, 2'b01);
    checkOutput("stall_catch0", 32'(follow[3:0]), 32'd15);
    applyStimulus(2'b00, 2'b01, 2'b01);
    checkOutput("stall_wrap0", 32'(lead[3:0]), 32'd0);

    // Clear on ch1 wins over both steps; ch0 untouched.
    for (int k = 0; k < 7; k++) applyStimulus(2'b00, 2'b11, 2'b00);
    checkOutput("pre_clr_lead1", 32'(lead[7:4]), 32'd7);
    applyStimulus(2'b10, 2'b10, 2'b10);
    checkOutput("clr_lead1", 32'(lead[7:4]), 32'd0);
    checkOutput("clr_lead0", 32'(lead[3:0]), 32'd7);

    // Randomized traffic with occasional clears.
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] c;
      for (int i = 0; i < N; i++) c[i] = ($urandom_range(0, 15) == 0);
      applyStimulus(c, N'($urandom), N'($urandom));
    end

    // Asynchronous reset between edges takes effect immediately.
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_lead", 32'(lead), 32'd0);
    checkOutput("async_follow", 32'(follow), 32'd0);
    checkOutput("async_viol", 32'(viol), 32'd0);
    applyStimulus(2'b00, 2'b11, 2'b11);
    rst_n = 1'b1;

    for (int k = 0; k < 100; k++) begin
      applyStimulus(N'($urandom_range(0, 7) == 0), N'($urandom), N'($urandom));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
